// File: rtl/fetch_pkg.sv
// Shared types for the LEGv8 fetch stage.
// IF/ID bundle, fetch FSM states and the address legality helper.
package fetch_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    logic   valid;
    instr_t instr;
    addr_t  pc;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  typedef enum logic {
    FETCH,
    FAULT
  } fetch_state_e;

  // Word aligned and fully inside memory; 65 bits so a+3 cannot wrap.
  function automatic logic addr_legal(
    input addr_t       a,
    input int unsigned mem_bytes
  );
    logic [64:0] last;
    last = {1'b0, a} + 65'd3;
    return (a[1:0] == 2'b00) && (last < 65'(mem_bytes));
  endfunction

endpackage

// File: rtl/br_target_calc.sv
// Branch target adder: br_pc + (sext(imm) << 2).
// Shared with the execute stage.
module br_target_calc
  import fetch_pkg::*;
(
  input  addr_t       br_pc,
  input  logic        br_uncond,
  input  logic [25:0] br_imm26,
  input  logic [18:0] br_imm19,
  output addr_t       target
);

  addr_t off;

  always_comb begin
    off = br_uncond ? {{38{br_imm26[25]}}, br_imm26}
                    : {{45{br_imm19[18]}}, br_imm19};
    target = br_pc + (off << 2);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: pc, IF/ID register, redirect/stall
// handling and a sticky fault on illegal fetch addresses.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] instr_addr,
  input  logic [31:0] instr_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_uncond,
  input  logic [25:0] br_imm26,
  input  logic [18:0] br_imm19,
  input  logic [63:0] br_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [63:0] ifid_pc,
  output logic        fault
);

  addr_t        pc;
  addr_t        pc_inc;
  addr_t        target;
  ifid_t        ifid;
  fetch_state_e state;
  logic         fault_q;

  br_target_calc u_tgt (
    .br_pc     (br_pc),
    .br_uncond (br_uncond),
    .br_imm26  (br_imm26),
    .br_imm19  (br_imm19),
    .target    (target)
  );

  assign pc_inc = pc + 64'd4;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= FETCH;
      pc      <= '0;
      ifid    <= BUBBLE;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          unique case (1'b1)
            br_taken: begin
              ifid <= BUBBLE;
              if (addr_legal(target, MEM_BYTES)) begin
                pc <= target;
              end else begin
                fault_q <= 1'b1;
                state   <= FAULT;
              end
            end
            (!br_taken && stall): begin
            end
            default: begin
              ifid <= '{valid: 1'b1,
                        instr: instr_rdata,
                        pc:    pc};
              if (addr_legal(pc_inc, MEM_BYTES)) begin
                pc <= pc_inc;
              end else begin
                fault_q <= 1'b1;
                state   <= FAULT;
              end
            end
          endcase
        end
        FAULT: begin
          fault_q <= 1'b1;
          if (!(stall && !br_taken)) begin
            ifid <= BUBBLE;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign instr_addr = pc;
  assign ifid_valid = ifid.valid;
  assign ifid_instr = ifid.instr;
  assign ifid_pc    = ifid.pc;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch with a behavioral ROM
// whose word n is 32'h1000_0000 + n.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        stall;
  logic        br_taken;
  logic        br_uncond;
  logic [25:0] br_imm26;
  logic [18:0] br_imm19;
  logic [63:0] br_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instr_rdata = 32'h1000_0000 + {24'd0, instr_addr[9:2]};

  instr_fetch #(.MEM_BYTES(1024)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_uncond   (br_uncond),
    .br_imm26    (br_imm26),
    .br_imm19    (br_imm19),
    .br_pc       (br_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .fault       (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        br;
    logic        unc;
    logic [25:0] i26;
    logic [18:0] i19;
    logic [63:0] bpc;
    logic [63:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_f;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic s, input logic b, input logic u,
    input logic [25:0] i26, input logic [18:0] i19,
    input logic [63:0] bp, input logic [63:0] ea,
    input logic ev, input logic [31:0] ei,
    input logic [63:0] ep, input logic ef
  );
    vec_t v;
    v.rst_n = r;  v.stl = s;  v.br = b;  v.unc = u;
    v.i26 = i26;  v.i19 = i19;  v.bpc = bp;
    v.e_addr = ea;  v.e_v = ev;  v.e_instr = ei;
    v.e_pc = ep;  v.e_f = ef;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    reset_n   = v.rst_n;
    stall     = v.stl;
    br_taken  = v.br;
    br_uncond = v.unc;
    br_imm26  = v.i26;
    br_imm19  = v.i19;
    br_pc     = v.bpc;
    @(posedge clk);
    #1;
    chk({tag, ".addr"},  instr_addr, v.e_addr);
    chk({tag, ".valid"}, {63'd0, ifid_valid}, {63'd0, v.e_v});
    chk({tag, ".instr"}, {32'd0, ifid_instr}, {32'd0, v.e_instr});
    chk({tag, ".pc"},    ifid_pc, v.e_pc);
    chk({tag, ".fault"}, {63'd0, fault}, {63'd0, v.e_f});
  endtask

  localparam logic [31:0] W0 = 32'h1000_0000;
  localparam logic [25:0] M1_26 = 26'h3FF_FFFF;
  localparam logic [25:0] M2_26 = 26'h3FF_FFFE;

  vec_t tv_a[$];
  vec_t tv_b[$];
  vec_t tv_c[$];

  initial begin
    logic [63:0] prev;
    bit          hit;

    // reset, free run, B back, CBZ with stall, stall x3, release
    tv_a.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0,  4,1,W0+0,0,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0,  8,1,W0+1,4,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0, 12,1,W0+2,8,0));
    tv_a.push_back(mk(1,0,1,1,M2_26,0,8, 0,0,0,0,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0,  4,1,W0+0,0,0));
    tv_a.push_back(mk(1,1,1,0,0,3,4, 16,0,0,0,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0, 20,1,W0+4,16,0));
    tv_a.push_back(mk(1,1,0,0,0,0,0, 20,1,W0+4,16,0));
    tv_a.push_back(mk(1,1,0,0,0,0,0, 20,1,W0+4,16,0));
    tv_a.push_back(mk(1,1,0,0,0,0,0, 20,1,W0+4,16,0));
    tv_a.push_back(mk(1,0,0,0,0,0,0, 24,1,W0+5,20,0));

    // at pc=1020: fault, stall holds, flush, br ignored, reset
    tv_b.push_back(mk(1,0,0,0,0,0,0, 1020,1,W0+255,1020,1));
    tv_b.push_back(mk(1,1,0,0,0,0,0, 1020,1,W0+255,1020,1));
    tv_b.push_back(mk(1,1,1,0,0,1,0, 1020,0,0,0,1));
    tv_b.push_back(mk(1,0,1,0,0,1,0, 1020,0,0,0,1));
    tv_b.push_back(mk(1,0,0,0,0,0,0, 1020,0,0,0,1));
    tv_b.push_back(mk(0,0,0,0,0,0,0,    0,0,0,0,0));

    // target boundaries: 1020 legal, 1024 and -4 illegal
    tv_c.push_back(mk(1,0,1,1,1,0,1016, 1020,0,0,0,0));
    tv_c.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0));
    tv_c.push_back(mk(1,0,1,0,0,1,1020,    0,0,0,0,1));
    tv_c.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0));
    tv_c.push_back(mk(1,0,0,0,0,0,0,       4,1,W0+0,0,0));
    tv_c.push_back(mk(1,0,1,1,M1_26,0,0,   4,0,0,0,1));
    tv_c.push_back(mk(1,0,0,0,0,0,0,       4,0,0,0,1));
    tv_c.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0));

    reset_n = 1'b0;
    stall = 1'b0;  br_taken = 1'b0;  br_uncond = 1'b0;
    br_imm26 = '0;  br_imm19 = '0;  br_pc = '0;
    @(posedge clk);
    #1;

    foreach (tv_a[i]) step(tv_a[i], $sformatf("a%0d", i));

    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (instr_addr == 64'd1020) begin
        hit = 1'b1;
        break;
      end
      prev = instr_addr;
      step(mk(1,0,0,0,0,0,0, prev + 64'd4, 1,
              W0 + 32'(prev >> 2), prev, 0),
           $sformatf("run%0d", n));
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL run_to_1020: got addr %h expected %h",
               instr_addr, 64'd1020);
    end

    foreach (tv_b[i]) step(tv_b[i], $sformatf("b%0d", i));
    foreach (tv_c[i]) step(tv_c[i], $sformatf("c%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction-memory read interface. It owns the program counter, drives the byte address to the combinational instruction ROM, captures the returned word into an IF/ID pipeline register, and applies stalls and branch redirects supplied by later stages. It sits between the instruction memory and the decode stage of the pipelined LEGv8 CPU.

## Interface
Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes. Must be a power of two and greater than 4.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset. It is sampled on posedge clk.
- instr_addr  out  64  byte address to the instruction memory; always equals pc.
- instr_rdata  in  32  word returned combinationally by the memory for instr_addr.
- stall  in  1  hold pc and the IF/ID register.
- br_taken  in  1  redirect fetch this cycle.
- br_uncond  in  1  1 selects the imm26 offset (B); 0 selects the imm19 offset (CBZ/B.cond).
- br_imm26  in  26  signed word offset.
- br_imm19  in  19  signed word offset.
- br_pc  in  64  byte address of the branching instruction.
- ifid_valid  out  1  the IF/ID register holds a real instruction.
- ifid_instr  out  32  captured instruction.
- ifid_pc  out  64  byte address of ifid_instr.
- fault  out  1  sticky flag for an illegal fetch address.

## Operation
- Reset value of every output is 0. The FSM resets to FETCH.
- FSM states are FETCH and FAULT.
- Branch target: target = br_pc + (sext(imm) << 2).
  - imm is br_imm26 when br_uncond=1, otherwise br_imm19.
  - Sign-extend to 64 bits before the shift. Arithmetic is modulo 2^64.
- Next-pc candidate nxt:
  - target when br_taken=1;
  - otherwise pc when stall=1;
  - otherwise pc+4.
- Legality check: an address a is legal iff a[1:0]==0 and a+3 < MEM_BYTES, computed as an unsigned 64-bit compare with no wrap.
- Per-cycle behavior in FETCH, in priority order:
  1. reset_n=0: everything returns to its reset value.
  2. br_taken=1: pc <= target. IF/ID <= bubble (valid=0, instr=0, pc=0). stall is ignored.
  3. stall=1: pc and IF/ID hold their values.
  4. Otherwise: pc <= pc+4. IF/ID <= {1, instr_rdata, pc}.
- Fault: in FETCH, if the pc update from case 2 or case 4 would produce an illegal nxt:
  - pc holds and does not load nxt;
  - fault <= 1 and the state moves to FAULT;
  - case 4 still captures the current instruction into IF/ID; case 2 still inserts a bubble.
- FAULT state:
  - pc holds, and fault stays 1;
  - IF/ID loads a bubble every cycle unless stall=1 and br_taken=0, in which case it holds;
  - br_taken is ignored;
  - only reset_n=0 leaves FAULT.

## Timing
- Fetch address to IF/ID capture latency is 1 cycle. instr_rdata is sampled at the same posedge that advances pc.
- Redirect: br_taken is asserted in cycle N. instr_addr = target in cycle N+1. The word fetched in cycle N is discarded, giving exactly one bubble. The target instruction appears in IF/ID in cycle N+2.
- br_taken and stall high together: the redirect wins, and the IF/ID register is flushed rather than held.
- Stall held for k cycles: instr_addr and IF/ID are constant for k cycles, and no instruction is lost or duplicated.
- Reset mid-operation (including in FAULT): takes effect on the next posedge, after which pc=0, IF/ID is a bubble and fault=0.
- No combinational path exists from the br_* or stall inputs to instr_addr; instr_addr is registered.

## Structure
- Package fetch_pkg holds:
  - typedef addr_t (logic [63:0]) and typedef instr_t (logic [31:0]);
  - the ifid_t struct {valid, instr, pc};
  - the BUBBLE constant;
  - the fetch_state_e enum {FETCH, FAULT}.
- Sub-module br_target_calc, combinational: inputs br_pc, br_uncond, br_imm26, br_imm19; output target. It is reusable by the execute stage.
- The top level contains the FSM, the pc register, the IF/ID register and the legality check.

## Test plan
All scenarios use MEM_BYTES=1024 and a behavioral ROM whose word n is 32'h1000_0000+n.
- Reset, then run free for 4 cycles -> instr_addr goes 0,4,8,12. ifid_pc goes 0,4,8 with ifid_instr 1000_0000, 1000_0001, 1000_0002. ifid_valid is 0 in the first cycle after reset.
- At pc=12: br_taken=1, br_uncond=1, br_imm26=-2, br_pc=8 -> instr_addr=0 next cycle. ifid_valid=0 for one cycle, then ifid_pc=0.
- br_taken=1, br_uncond=0, br_imm19=3, br_pc=4, with stall=1 in the same cycle -> instr_addr=16, IF/ID is a bubble, and ifid_instr=1000_0004 two cycles later.
- stall=1 for 3 cycles at pc=20 -> instr_addr stays 20 and IF/ID is unchanged. After release, instr_addr=24 and ifid_pc=20.
- Run to pc=1020 -> word 255 is captured and fault=1. instr_addr stays 1020 and ifid_valid=0 thereafter. br_taken is ignored. reset_n=0 clears the fault.
- br_taken with br_pc=0 and br_imm26=-1 (target 0xFFFF_FFFF_FFFF_FFFC) -> fault=1, pc holds, one bubble.
